// File: rtl/switch_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// switch_debouncer_pkg
// Shared constants for the board switch debouncer.
//   SW_WIDTH             : number of board switches handled by the debouncer
//   DEBOUNCE_MAX_DEFAULT : default stable-cycle count before a level is accepted
//   SYNC_STAGES_DEFAULT  : default synchronizer depth
// -----------------------------------------------------------------------------
package switch_debouncer_pkg;

    localparam int unsigned SW_WIDTH             = 8;
    localparam int unsigned DEBOUNCE_MAX_DEFAULT = 50000;
    localparam int unsigned SYNC_STAGES_DEFAULT  = 2;

endpackage : switch_debouncer_pkg

// File: rtl/switch_debouncer_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// Synchronizer, stability counter and accepted level for one switch input.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   raw     : asynchronous switch level
//   stable  : debounced level (registered)
//   update  : combinational strobe, high in the cycle before stable takes a
//             new value, so the top can register its changed flag on the same
//             edge that stable changes
// -----------------------------------------------------------------------------
module debounce_bit #(
    parameter int unsigned DEBOUNCE_MAX = 50000,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic update
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       count;
    logic                   sync_bit;
    logic                   differs;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign differs  = (sync_bit != stable);
    assign update   = differs && (count == CNT_LAST);

    // Raw level enters at bit 0 and shifts toward the top bit, which is the
    // only one used for comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Any cycle that agrees with the accepted level restarts the count, so a
    // glitch shorter than DEBOUNCE_MAX cycles never reaches the accept point.
    // The count saturates by construction: reaching CNT_LAST while still
    // different always accepts and clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            stable <= 1'b0;
        end else if (!differs) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count  <= '0;
            stable <= sync_bit;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Debounces the board switches for the I/O read mux and flags changes.
//   clk            : system clock, rising edge
//   rst            : asynchronous active-high reset
//   switches_raw   : asynchronous board switch levels
//   ack            : clears change_pending (I/O-space read decode)
//   switches       : debounced switch value (registered)
//   changed        : one-cycle pulse in the cycle switches shows a new value
//   change_pending : sticky flag, set on change, cleared by ack
// -----------------------------------------------------------------------------
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MAX = DEBOUNCE_MAX_DEFAULT,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] switches_raw,
    input  logic                ack,
    output logic [SW_WIDTH-1:0] switches,
    output logic                changed,
    output logic                change_pending
);

    logic [SW_WIDTH-1:0] bit_update;
    logic                any_update;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_MAX (DEBOUNCE_MAX),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_debounce_bit (
            .clk    (clk),
            .rst    (rst),
            .raw    (switches_raw[i]),
            .stable (switches[i]),
            .update (bit_update[i])
        );
    end

    assign any_update = |bit_update;

    // changed is registered from the update strobe so it rises on the same
    // edge as switches. An ack seen while changed is still high does not
    // clear the flag, so a read racing a fresh change never loses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed        <= 1'b0;
            change_pending <= 1'b0;
        end else begin
            changed <= any_update;
            if (any_update) begin
                change_pending <= 1'b1;
            end else if (ack && !changed) begin
                change_pending <= 1'b0;
            end
        end
    end

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
// Directed bench for switch_debouncer with DEBOUNCE_MAX=4, SYNC_STAGES=2.
// Inputs change 1 ns after a rising edge and outputs are sampled at that same
// point, so "N edges after sampling" means N calls of stepCycles(1) after the
// one that carries the first sampling edge.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

    logic       clk;
    logic       rst;
    logic [7:0] switches_raw;
    logic       ack;
    logic [7:0] switches;
    logic       changed;
    logic       change_pending;

    int checkCount;
    int failCount;

    switch_debouncer #(
        .DEBOUNCE_MAX (4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .switches_raw   (switches_raw),
        .ack            (ack),
        .switches       (switches),
        .changed        (changed),
        .change_pending (change_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] raw, input logic a);
        switches_raw = raw;
        ack          = a;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkAll(input string tag, input logic [7:0] sw,
                            input logic ch, input logic pend);
        checkOutput({tag, ".switches"}, {24'h0, switches}, {24'h0, sw});
        checkOutput({tag, ".changed"}, {31'h0, changed}, {31'h0, ch});
        checkOutput({tag, ".pending"}, {31'h0, change_pending}, {31'h0, pend});
    endtask

    // Drops rst asynchronously mid-cycle and releases it before the next edge.
    task automatic pulseReset();
        rst = 1'b1;
        #1;
        checkAll("async_reset", 8'h00, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0);

        // Reset state, held without relying on the clock.
        #23;
        checkAll("reset", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle with raw low: nothing ever moves.
        for (int i = 0; i < 8; i++) begin
            stepCycles(1);
            checkAll("idle", 8'h00, 1'b0, 1'b0);
        end

        // Bit0 high for two sampled cycles only: must be rejected.
        applyStimulus(8'h01, 1'b0);
        stepCycles(2);
        applyStimulus(8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            stepCycles(1);
            checkAll("glitch", 8'h00, 1'b0, 1'b0);
        end

        // 00 -> A5 held: update lands on the 6th edge (5 after sampling).
        applyStimulus(8'hA5, 1'b0);
        stepCycles(5);
        checkAll("a5_before", 8'h00, 1'b0, 1'b0);
        stepCycles(1);
        checkAll("a5_update", 8'hA5, 1'b1, 1'b1);
        stepCycles(1);
        checkAll("a5_after", 8'hA5, 1'b0, 1'b1);

        // ack clears the flag on the next edge; a second ack is harmless.
        applyStimulus(8'hA5, 1'b1);
        stepCycles(1);
        checkAll("ack_clear", 8'hA5, 1'b0, 1'b0);
        stepCycles(1);
        checkAll("ack_idle", 8'hA5, 1'b0, 1'b0);
        applyStimulus(8'hA5, 1'b0);

        // A5 -> 00 with ack held across the update edge and the changed cycle.
        applyStimulus(8'h00, 1'b0);
        stepCycles(5);
        checkAll("race_before", 8'hA5, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1);
        stepCycles(1);
        checkAll("race_update", 8'h00, 1'b1, 1'b1);
        stepCycles(1);
        checkAll("race_changed", 8'h00, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0);
        stepCycles(1);
        checkAll("race_hold", 8'h00, 1'b0, 1'b1);

        // FF for 3 edges, reset mid-count, then a fresh full debounce.
        applyStimulus(8'hFF, 1'b0);
        stepCycles(3);
        pulseReset();
        stepCycles(5);
        checkAll("post_rst_before", 8'h00, 1'b0, 1'b0);
        stepCycles(1);
        checkAll("post_rst_update", 8'hFF, 1'b1, 1'b1);
        stepCycles(1);
        checkAll("post_rst_after", 8'hFF, 1'b0, 1'b1);

        // Back to zero, then bit7 followed two cycles later by bit0.
        applyStimulus(8'h00, 1'b0);
        pulseReset();
        stepCycles(3);
        applyStimulus(8'h80, 1'b0);
        stepCycles(2);
        applyStimulus(8'h81, 1'b0);
        stepCycles(3);
        checkAll("stagger_before", 8'h00, 1'b0, 1'b0);
        stepCycles(1);
        checkAll("stagger_bit7", 8'h80, 1'b1, 1'b1);
        stepCycles(1);
        checkAll("stagger_gap", 8'h80, 1'b0, 1'b1);
        stepCycles(1);
        checkAll("stagger_bit0", 8'h81, 1'b1, 1'b1);
        stepCycles(1);
        checkAll("stagger_final", 8'h81, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule : tb_switch_debouncer

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001: Parameter DEBOUNCE_MAX, default 50000, SHALL set the number of consecutive stable synchronized cycles required to accept a new switch level; legal range 2..65535.
REQ-002: Parameter SYNC_STAGES, default 2, SHALL set the synchronizer flop depth; legal range 2..3.
REQ-003: clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004: rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005: switches_raw  input  8  SHALL carry the asynchronous board switch levels.
REQ-006: ack  input  1  SHALL clear change_pending; it is driven by the I/O-space read decode (address[12] & ~mem_wr).
REQ-007: switches  output  8  SHALL carry the debounced switch value presented to the data-memory/IO read mux, registered.
REQ-008: changed  output  1  SHALL be a one-cycle pulse marking a switches update, registered.
REQ-009: change_pending  output  1  SHALL be a sticky flag indicating that switches changed since the last ack, registered.

Function
REQ-010: Each bit of switches_raw SHALL pass through a SYNC_STAGES-deep flop chain before any comparison.
REQ-011: Each bit SHALL own a counter of width clog2(DEBOUNCE_MAX).
REQ-012: On each edge where the synchronized bit equals switches[i], the counter SHALL clear to 0.
REQ-013: On each edge where the synchronized bit differs from switches[i] and the counter equals DEBOUNCE_MAX-1, switches[i] SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-014: On each edge where the synchronized bit differs from switches[i] and the counter is below DEBOUNCE_MAX-1, the counter SHALL increment by 1.
REQ-015: The counter SHALL never wrap; its value SHALL never exceed DEBOUNCE_MAX-1.
REQ-016: Latency: a raw level held steady SHALL appear on switches exactly SYNC_STAGES+DEBOUNCE_MAX-1 rising edges after the edge that first samples it.
REQ-017: Glitches: any raw pulse shorter than DEBOUNCE_MAX synchronized cycles SHALL leave switches unchanged and SHALL reset that bit's counter.
REQ-018: Bits SHALL debounce independently, and several bits MAY update on the same edge.
REQ-019: changed SHALL be high for exactly the one cycle in which switches first shows the new value, and SHALL be low otherwise.
REQ-020: Multiple bits updating on the same edge SHALL produce a single changed pulse.
REQ-021: change_pending SHALL set on any edge where changed is asserted.
REQ-022: change_pending SHALL clear on an edge where ack=1 and changed=0.
REQ-023: When changed and ack coincide, change_pending SHALL remain 1 (set wins).
REQ-024: ack while change_pending=0 SHALL have no effect.

Reset
REQ-025: Asserting rst SHALL immediately clear the synchronizer flops, counters, switches, changed and change_pending to 0, regardless of clk.
REQ-026: A reset mid-debounce SHALL discard the partial count, so that no update occurs from a pre-reset count.
REQ-027: After rst deasserts with a switch raw-high, that bit SHALL debounce from 0 per REQ-016 and SHALL raise changed and change_pending.

Structure
REQ-028: A shared package SHALL hold SW_WIDTH=8, DEBOUNCE_MAX_DEFAULT=50000 and SYNC_STAGES_DEFAULT=2.
REQ-029: A sub-module debounce_bit (synchronizer, counter and stable bit for one input) SHALL be instantiated SW_WIDTH times via generate.
REQ-030: The top level SHALL contain only the OR-reduce of the per-bit update strobes and the changed/change_pending flops.

Verification (DEBOUNCE_MAX=4, SYNC_STAGES=2)
REQ-031: rst=1, then raw=8'h00 -> switches=8'h00, changed=0 and change_pending=0 hold indefinitely.
REQ-032: raw 8'h00->8'hA5 held -> switches=8'hA5 exactly 5 edges after the first sampling edge, changed high 1 cycle, change_pending=1.
REQ-033: raw bit0 glitches high for 2 cycles, then returns -> switches stays 8'h00, changed never asserts.
REQ-034: ack pulses while change_pending=1 -> change_pending=0 next edge; ack coincident with changed -> change_pending stays 1.
REQ-035: raw=8'hFF held 3 edges, rst pulsed mid-count, raw kept 8'hFF -> all outputs 0 immediately, switches=8'hFF exactly 5 edges after the first post-reset sampling edge.
REQ-036: bit7 rises, and bit0 rises 2 cycles later -> two separate changed pulses 2 cycles apart, final switches=8'h81.
